// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the execute stage and a DATA_W-wide data bus.
// Aligns requests to bus words, generates byte enables, assembles and extends
// load data, and returns a one-cycle response pulse.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, word-crossing
// accesses are split into two bus beats; when undefined they complete with
// resp_err = 1 and no bus activity.
//
// Handshake summary: a request is accepted on the edge where req_valid and
// req_ready are both high (req_ready is high only in IDLE). A bus beat holds
// d_rd_req/d_wr_req, d_addr, d_be and d_wr_data steady until the matching
// d_*_ready is sampled high on an edge; ready while the request is low is
// ignored. resp_valid is a single-cycle pulse with no backpressure.
module lsu_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [4:0]          resp_rd,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   d_addr,
  output logic                d_rd_req,
  input  logic                d_rd_ready,
  output logic                d_wr_req,
  input  logic                d_wr_ready,
  output logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_rd_data,
  output logic [DATA_W-1:0]   d_wr_data
);

  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int EW = OB + 2;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [4:0]          rd_q, rd_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rbuf0_q, rbuf0_d;
  logic [DATA_W-1:0]   rbuf1_q, rbuf1_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic                split_q, split_d;
`endif

  // Request decode (combinational, only meaningful while in IDLE)
  logic [OB-1:0] req_off;
  logic [EW-1:0] req_end;
  logic          req_cross;
  logic          req_illegal;
  logic          req_err;

  assign req_off   = req_addr[OB-1:0];
  assign req_end   = EW'(req_off) + (EW'(1) << req_funct3[1:0]);
  assign req_cross = req_end > EW'(NB);

  // Doubleword sizes and unsigned word loads need a 64-bit bus; stores have no
  // unsigned form; funct3 = 111 is never a load or store.
  assign req_illegal = (req_funct3 == 3'b111) ||
                       (req_we && req_funct3[2]) ||
                       ((DATA_W == 32) && ((req_funct3[1:0] == 2'd3) || (req_funct3 == 3'b110)));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign req_err = req_illegal;
`else
  assign req_err = req_illegal || req_cross;
`endif

  assign req_ready = (state_q == IDLE);

  // Lane geometry of the captured request. The "wide" vectors span two bus
  // words: the low half belongs to beat0, the high half to beat1.
  logic [OB-1:0]       off_q;
  logic [3:0]          bytes_q;
  logic [NB-1:0]       lane_ones;
  logic [DATA_W-1:0]   data_mask;
  logic [2*NB-1:0]     be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic [2*DATA_W-1:0] rd_wide;
  logic [DATA_W-1:0]   ld_raw;
  logic                ld_sign;
  logic [DATA_W-1:0]   ld_ext;
  logic [ADDR_W-1:0]   base_addr;

  assign off_q     = addr_q[OB-1:0];
  assign bytes_q   = 4'd1 << f3_q[1:0];
  assign lane_ones = ~({NB{1'b1}} << bytes_q);
  assign base_addr = {addr_q[ADDR_W-1:OB], OB'(0)};
  assign be_wide   = {NB'(0), lane_ones} << off_q;
  assign wd_wide   = {DATA_W'(0), wdata_q & data_mask} << {off_q, 3'b000};
  assign rd_wide   = {rbuf1_q, rbuf0_q} >> {off_q, 3'b000};
  assign ld_raw    = rd_wide[DATA_W-1:0] & data_mask;

`ifndef LSU_MISALIGN_SPLIT_EN
  // Beat1 halves have no consumer when splitting is not built.
  logic unused_hi;
  assign unused_hi = ^{be_wide[2*NB-1:NB], wd_wide[2*DATA_W-1:DATA_W]};
`endif

  // Expand the byte mask to a bit mask and pick the sign bit for the access size
  always_comb begin
    data_mask = '0;
    for (int i = 0; i < NB; i++) data_mask[8*i +: 8] = {8{lane_ones[i]}};
    case (f3_q[1:0])
      2'd0:    ld_sign = ld_raw[7];
      2'd1:    ld_sign = ld_raw[15];
      2'd2:    ld_sign = ld_raw[31];
      default: ld_sign = ld_raw[DATA_W-1];
    endcase
    ld_ext = ld_raw | ((ld_sign && !f3_q[2]) ? ~data_mask : '0);
  end

  // Bus and response outputs decoded from the current state
  always_comb begin
    d_rd_req   = 1'b0;
    d_wr_req   = 1'b0;
    d_addr     = '0;
    d_be       = '0;
    d_wr_data  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    resp_rd    = '0;
    case (state_q)
      BEAT0: begin
        d_rd_req  = ~we_q;
        d_wr_req  = we_q;
        d_addr    = base_addr;
        d_be      = be_wide[NB-1:0];
        d_wr_data = we_q ? wd_wide[DATA_W-1:0] : '0;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        d_rd_req  = ~we_q;
        d_wr_req  = we_q;
        d_addr    = base_addr + ADDR_W'(NB);
        d_be      = be_wide[2*NB-1:NB];
        d_wr_data = we_q ? wd_wide[2*DATA_W-1:DATA_W] : '0;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : ld_ext;
        resp_rd    = we_q ? 5'd0 : rd_q;
      end
      default: ;
    endcase
  end

  logic beat_done;
  assign beat_done = (d_rd_req && d_rd_ready) || (d_wr_req && d_wr_ready);

  // Next-state logic and request/load-data capture
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    rbuf0_d = rbuf0_q;
    rbuf1_d = rbuf1_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d = split_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          err_d   = req_err;
          rbuf0_d = '0;
          rbuf1_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d = req_cross;
`endif
          state_d = req_err ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        if (beat_done) begin
          rbuf0_d = d_rd_data;
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = split_q ? BEAT1 : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        if (beat_done) begin
          rbuf1_d = d_rd_data;
          state_d = RESP;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      rbuf0_q <= '0;
      rbuf1_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      rbuf0_q <= rbuf0_d;
      rbuf1_q <= rbuf1_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= split_d;
`endif
    end
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
Parametrised load/store unit that sits between the core's execute stage and the data bus. It takes one memory request per transaction over a valid/ready interface and aligns it to the bus word (DATA_W wide). It generates byte enables and, when an access crosses a bus word boundary, splits it into two bus beats. Load data is reassembled, then sign- or zero-extended, and returned on a one-cycle response pulse.

Parameters:
DATA_W, 32, bus and register width; legal values 32 or 64; NB = DATA_W/8, OB = log2(NB)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V load/store funct3; [1:0] = size (0 B, 1 H, 2 W, 3 D), [2] = unsigned load
req_addr  in  ADDR_W  byte address, any alignment
req_wdata  in  DATA_W  store data, right-justified
req_rd  in  5  load destination register tag
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_rd  out  5  tag of the request; 0 for stores
resp_err  out  1  illegal funct3, or misaligned access when split is disabled
d_addr  out  ADDR_W  bus address, low OB bits always 0
d_rd_req  out  1  bus read request
d_rd_ready  in  1  read data valid / read accepted
d_wr_req  out  1  bus write request
d_wr_ready  in  1  write accepted
d_be  out  NB  byte enables
d_rd_data  in  DATA_W  read data
d_wr_data  out  DATA_W  lane-aligned write data

Behaviour:
- Reset (asynchronous, rstb low): state IDLE; d_rd_req, d_wr_req, resp_valid, resp_err = 0; d_addr, d_be, d_wr_data, resp_rdata, resp_rd = 0; req_ready = 1 once in IDLE.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE -> BEAT0 on req_valid & req_ready, with all request fields captured.
  - IDLE -> RESP directly on an illegal request (resp_err = 1, no bus activity).
  - BEAT0 -> BEAT1 on beat completion if the access is split, otherwise -> RESP.
  - BEAT1 -> RESP on beat completion.
  - RESP -> IDLE unconditionally.
- Illegal requests: size 3 when DATA_W = 32; unsigned word load when DATA_W = 32; unsigned store (funct3[2] = 1 with req_we = 1); funct3 = 3'b111.
- Address split: off = addr[OB-1:0], bytes = 1 << size. The access is split when off + bytes > NB.
  - Beat0: d_addr = {addr[ADDR_W-1:OB], 0}; d_be = (bytes-mask << off) truncated to NB bits.
  - Beat1: d_addr = beat0 address + NB, wrapping modulo 2^ADDR_W; d_be = the remaining low bytes.
- Store data: d_wr_data = wdata << (8*off) in beat0; wdata >> (8*(NB-off)) in beat1. Unused lanes are 0.
- Bus handshake:
  - The request stays high and addr/be/wr_data stay stable until the matching ready is sampled high at a clock edge; that edge completes the beat.
  - Ready may be high in the same cycle the request first rises (zero wait state).
  - Ready while the corresponding request is low is ignored.
  - The request drops in the cycle after completion unless BEAT1 follows, in which case it stays high with the new address.
- Load assembly: beat0 lanes [off..NB-1] go to result bytes [0..NB-1-off]; beat1 lanes [0..] go to the following result bytes. The result is then truncated to size and sign-extended (funct3[2] = 0) or zero-extended.
- Latency: request accepted at edge 0 -> bus request in cycle 1 -> resp_valid in cycle 2 with zero waits. A split access adds 1 cycle plus its wait states. Throughput is at most one request per 3 cycles.
- resp_valid is high for exactly one cycle, with no backpressure. resp_rdata, resp_rd and resp_err are valid only while resp_valid = 1 and are 0 otherwise.
- Reset mid-transaction abandons the access: the bus request drops immediately and no response follows.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined: word-crossing accesses are split into two beats as described above.
- Undefined: a word-crossing access goes IDLE -> RESP with resp_err = 1 and no bus request. BEAT1 logic is not built. In-word misalignment (e.g. a halfword at offset 1) is still a single legal beat.

Test Plan:
- LW 0x100, d_rd_data = 0xDEADBEEF, ready in the same cycle -> d_addr = 0x100, d_be = 4'hF, resp_valid 2 cycles after accept, resp_rdata = 0xDEADBEEF, resp_rd echoed.
- LB 0x103 with d_rd_data = 0x80112233 -> d_be = 4'h8, resp_rdata = 0xFFFFFF80; the same access as LBU -> 0x00000080.
- LW 0x102 with the macro defined:
  - Beat0: addr 0x100, be 4'hC, data 0xBBAA0000.
  - Beat1: addr 0x104, be 4'h3, data 0x0000DDCC.
  - Result: resp_rdata = 0xDDCCBBAA.
  - With the macro undefined: resp_err = 1 and d_rd_req never rises.
- SH 0x103, wdata 0x1234 -> beat0 addr 0x100 be 4'h8 wr_data 0x34000000; beat1 addr 0x104 be 4'h1 wr_data 0x00000012; resp_rdata = 0.
- LW 0x200 with d_rd_ready held low for 3 cycles -> d_rd_req, d_addr and d_be stable throughout, req_ready = 0, resp_valid 1 cycle after ready.
- Remaining cases:
  - LW 0xFFFFFFFE splits with beat1 at 0x00000000.
  - rstb pulsed low during BEAT1 -> d_rd_req = 0 asynchronously, no resp_valid after release.
  - funct3 = 3'b011 with DATA_W = 32 -> resp_err = 1 with no bus access.
